// File: rtl/fetch_unit_if.sv
// Fetch front-end bus: instruction-memory port, redirect input
// and the valid/ready fetch-queue output toward decode.
interface fetch_unit_if #(
    parameter int ADDR_WIDTH  = 64,
    parameter int INSTR_WIDTH = 32,
    parameter int QUEUE_DEPTH = 4
);
    localparam int CW = $clog2(QUEUE_DEPTH + 1);

    logic                   imem_req;
    logic [ADDR_WIDTH-1:0]  imem_addr;
    logic [INSTR_WIDTH-1:0] imem_rdata;
    logic                   redirect_valid;
    logic [ADDR_WIDTH-1:0]  redirect_pc;
    logic                   out_valid;
    logic                   out_ready;
    logic [ADDR_WIDTH-1:0]  out_pc;
    logic [INSTR_WIDTH-1:0] out_instr;
    logic [CW-1:0]          queue_count;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata,
        input  redirect_valid, redirect_pc,
        output out_valid, out_pc, out_instr, queue_count,
        input  out_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata,
        output redirect_valid, redirect_pc,
        input  out_valid, out_pc, out_instr, queue_count,
        output out_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Olivia pipelined fetch front end: PC register, 1-cycle imem
// request port and a decoupling fetch queue toward decode.
module fetch_unit #(
    parameter int                    ADDR_WIDTH  = 64,
    parameter int                    INSTR_WIDTH = 32,
    parameter int                    QUEUE_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    PC_STEP     = 4
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] STEP  = ADDR_WIDTH'(PC_STEP);
    localparam logic [ADDR_WIDTH-1:0] ALIGN = ~(STEP - 1'b1);

    logic [ADDR_WIDTH-1:0]  fetch_pc;
    logic [ADDR_WIDTH-1:0]  issued_pc;
    logic                   inflight;
    logic [PW-1:0]          head;
    logic [PW-1:0]          tail;
    logic [CW-1:0]          count;
    logic [ADDR_WIDTH-1:0]  q_pc    [QUEUE_DEPTH];
    logic [INSTR_WIDTH-1:0] q_instr [QUEUE_DEPTH];

    logic [CW:0] credit;
    logic        issue;
    logic        push;
    logic        pop;

    // Credit counts the in-flight slot so a response always has room.
    assign credit = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign issue  = !rst && !bus.redirect_valid
                    && (credit < (CW+1)'(QUEUE_DEPTH));
    assign push   = inflight && !bus.redirect_valid;
    assign pop    = bus.out_valid && bus.out_ready;

    assign bus.imem_req    = issue;
    assign bus.imem_addr   = fetch_pc;
    assign bus.out_valid   = (count != '0) && !bus.redirect_valid;
    assign bus.out_pc      = q_pc[head];
    assign bus.out_instr   = q_instr[head];
    assign bus.queue_count = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc  <= RESET_PC;
            issued_pc <= '0;
            inflight  <= 1'b0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                q_pc[i]    <= '0;
                q_instr[i] <= '0;
            end
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc  <= fetch_pc + STEP;
                issued_pc <= fetch_pc;
            end
            if (bus.redirect_valid) begin
                fetch_pc <= bus.redirect_pc & ALIGN;
                head     <= '0;
                tail     <= '0;
                count    <= '0;
            end else begin
                assert (!(push && !pop) || count < CW'(QUEUE_DEPTH));
                if (push) begin
                    q_pc[tail]    <= issued_pc;
                    q_instr[tail] <= bus.imem_rdata;
                    tail          <= tail + PW'(1);
                end
                if (pop) begin
                    head <= head + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end
endmodule
